ex13_window_accum: RTL and testbench

//   Downstream consumer of the 16-bit multiply-add pipeline result g.

---
 rtl/ex13_window_accum.sv | 160 ++++++++++++++++
 tb/tb_ex13_window_accum.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex13_window_accum.sv
// ----------------------------------------------------------------------------
// ex13_window_accum
//   Windowed statistics on the multiply-add pipeline result stream. Collects
//   2**LOG2_WIN valid samples, then holds the window sum, truncated average
//   and peak under a valid/ready handshake until the next stage takes them.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      pulse: begin a new window (IDLE, or HOLD together with out_ready)
//   in_valid   in_data carries a valid sample this cycle
//   in_data    sample, unsigned, DATA_W bits
//   out_ready  downstream accepts the held result (only looked at in HOLD)
//   busy       high while a window is being accumulated
//   out_valid  high while a finished result is held
//   out_sum    window sum, ACC_W bits, cannot overflow
//   out_avg    out_sum >> LOG2_WIN, truncated
//   out_max    largest sample of the window (unsigned)
//   overrun    sticky: a sample arrived while a result was held and was dropped
// ----------------------------------------------------------------------------
module ex13_window_accum #(
    parameter int DATA_W   = 16,
    parameter int LOG2_WIN = 3,
    localparam int ACC_W   = DATA_W + LOG2_WIN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_avg,
    output logic [DATA_W-1:0] out_max,
    output logic              overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [LOG2_WIN-1:0] CNT_LAST = '1;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [LOG2_WIN-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [ACC_W-1:0]    sum_q, sum_d;
    logic [DATA_W-1:0]   avg_q, avg_d;
    logic [DATA_W-1:0]   omax_q, omax_d;
    logic                overrun_q, overrun_d;

    logic [ACC_W-1:0]    acc_next;
    logic [DATA_W-1:0]   max_next;

    // Average is the upper DATA_W bits of the sum: a plain truncating shift.
    function automatic logic [DATA_W-1:0] avg_of(input logic [ACC_W-1:0] s);
        return s[ACC_W-1:LOG2_WIN];
    endfunction

    always_comb begin
        acc_next  = acc_q + ACC_W'(in_data);
        max_next  = (in_data > max_q) ? in_data : max_q;

        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        sum_d     = sum_q;
        avg_d     = avg_q;
        omax_d    = omax_q;
        overrun_d = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ACCUM;
                    acc_d     = '0;
                    cnt_d     = '0;
                    max_d     = '0;
                    overrun_d = 1'b0;
                end
            end

            S_ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_next;
                    max_d = max_next;
                    // Wraps back to 0 on the last sample of the window.
                    cnt_d = cnt_q + LOG2_WIN'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_HOLD;
                        sum_d   = acc_next;
                        avg_d   = avg_of(acc_next);
                        omax_d  = max_next;
                    end
                end
            end

            S_HOLD: begin
                if (in_valid) begin
                    overrun_d = 1'b1;
                end
                if (out_ready) begin
                    if (start) begin
                        // Back-to-back window: the new window starts clean,
                        // including a drop flagged in this very cycle.
                        state_d   = S_ACCUM;
                        acc_d     = '0;
                        cnt_d     = '0;
                        max_d     = '0;
                        overrun_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            max_q     <= '0;
            sum_q     <= '0;
            avg_q     <= '0;
            omax_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            sum_q     <= sum_d;
            avg_q     <= avg_d;
            omax_q    <= omax_d;
            overrun_q <= overrun_d;
        end
    end

    // Status flags decode straight from the state register, so they are
    // glitch-free and aligned with the held result.
    assign busy      = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_HOLD);
    assign out_sum   = sum_q;
    assign out_avg   = avg_q;
    assign out_max   = omax_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_ex13_window_accum.sv
// ----------------------------------------------------------------------------
// tb_ex13_window_accum
//   Self-checking bench for ex13_window_accum (DATA_W=16, LOG2_WIN=3).
//   Table of fixed windows, hand-written handshake/reset/start corner cases,
//   and random windows checked against a sum/divide/max reference.
// ----------------------------------------------------------------------------
module tb_ex13_window_accum;

    localparam int DATA_W   = 16;
    localparam int LOG2_WIN = 3;
    localparam int ACC_W    = DATA_W + LOG2_WIN;
    localparam int WIN      = 1 << LOG2_WIN;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;
    logic              busy;
    logic              out_valid;
    logic [ACC_W-1:0]  out_sum;
    logic [DATA_W-1:0] out_avg;
    logic [DATA_W-1:0] out_max;
    logic              overrun;

    int n_vec  = 0;
    int n_miss = 0;

    ex13_window_accum #(
        .DATA_W  (DATA_W),
        .LOG2_WIN(LOG2_WIN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_ready(out_ready),
        .busy     (busy),
        .out_valid(out_valid),
        .out_sum  (out_sum),
        .out_avg  (out_avg),
        .out_max  (out_max),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIN-1:0][DATA_W-1:0] s;
        logic [WIN-1:0][1:0]        g;
        logic [ACC_W-1:0]           e_sum;
        logic [DATA_W-1:0]          e_avg;
        logic [DATA_W-1:0]          e_max;
    } vec_t;

    vec_t vt[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: window statistics straight from their definitions.
    function automatic void model(input logic [WIN-1:0][DATA_W-1:0] s,
                                  output logic [ACC_W-1:0] es,
                                  output logic [DATA_W-1:0] ea,
                                  output logic [DATA_W-1:0] em);
        int unsigned tot = 0;
        int unsigned mx  = 0;
        for (int i = 0; i < WIN; i++) begin
            tot += s[i];
            if (s[i] > mx) mx = s[i];
        end
        es = ACC_W'(tot);
        ea = DATA_W'(tot / WIN);
        em = DATA_W'(mx);
    endfunction

    task automatic start_win();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic feed(input logic [WIN-1:0][DATA_W-1:0] s, input logic [WIN-1:0][1:0] g);
        for (int i = 0; i < WIN; i++) begin
            in_valid = 1'b0;
            repeat (int'(g[i])) tick();
            in_valid = 1'b1;
            in_data  = s[i];
            tick();
            chk("feed_valid", 32'(out_valid), (i == WIN - 1) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string nm, input logic [ACC_W-1:0] es,
                                input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] em);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_sum"},  32'(out_sum), 32'(es));
        chk({nm, "_avg"},  32'(out_avg), 32'(ea));
        chk({nm, "_max"},  32'(out_max), 32'(em));
    endtask

    task automatic release_idle(input logic [ACC_W-1:0] es);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("rel_valid", 32'(out_valid), 32'd0);
        chk("rel_busy",  32'(busy), 32'd0);
        chk("rel_keep_sum", 32'(out_sum), 32'(es));
    endtask

    initial begin
        logic [WIN-1:0][DATA_W-1:0] s;
        logic [WIN-1:0][1:0]        g;
        logic [ACC_W-1:0]           es;
        logic [DATA_W-1:0]          ea;
        logic [DATA_W-1:0]          em;

        reset     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Fixed windows with hand-computed results.
        for (int i = 0; i < WIN; i++) begin
            vt[0].s[i] = 16'h0100;  vt[0].g[i] = 2'd0;
            vt[1].s[i] = 16'(i);    vt[1].g[i] = 2'(i % 4);
            vt[2].s[i] = 16'hFFFF;  vt[2].g[i] = 2'd0;
            vt[3].s[i] = 16'h0000;  vt[3].g[i] = 2'd1;
            vt[4].s[i] = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
            vt[4].g[i] = 2'(3 - (i % 4));
        end
        vt[1].s[0] = 16'h004E;
        vt[0].e_sum = 19'h00800; vt[0].e_avg = 16'h0100; vt[0].e_max = 16'h0100;
        // 0x4E + (1+2+...+7) = 78 + 28 = 106
        vt[1].e_sum = 19'h0006A; vt[1].e_avg = 16'h000D; vt[1].e_max = 16'h004E;
        vt[2].e_sum = 19'h7FFF8; vt[2].e_avg = 16'hFFFF; vt[2].e_max = 16'hFFFF;
        vt[3].e_sum = 19'h00000; vt[3].e_avg = 16'h0000; vt[3].e_max = 16'h0000;
        vt[4].e_sum = 19'h3FFFC; vt[4].e_avg = 16'h7FFF; vt[4].e_max = 16'h8000;

        // Reset state.
        #12;
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_valid",   32'(out_valid), 32'd0);
        chk("rst_sum",     32'(out_sum), 32'd0);
        chk("rst_avg",     32'(out_avg), 32'd0);
        chk("rst_max",     32'(out_max), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        tick();

        // in_valid in IDLE is ignored and never flags overrun.
        in_valid = 1'b1;
        in_data  = 16'h1234;
        tick();
        in_valid = 1'b0;
        chk("idle_overrun", 32'(overrun), 32'd0);
        chk("idle_busy",    32'(busy), 32'd0);

        // Table-driven windows.
        for (int v = 0; v < 5; v++) begin
            start_win();
            feed(vt[v].s, vt[v].g);
            check_result($sformatf("tab%0d", v), vt[v].e_sum, vt[v].e_avg, vt[v].e_max);
            release_idle(vt[v].e_sum);
        end

        // HOLD with stalled downstream and incoming samples, then restart.
        start_win();
        for (int i = 0; i < WIN; i++) begin
            s[i] = 16'(i + 1);
            g[i] = 2'd0;
        end
        feed(s, g);
        check_result("hold", 19'h00024, 16'h0004, 16'h0008);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum",   32'(out_sum), 32'h24);
            chk("hold_max",   32'(out_max), 32'h8);
        end
        in_valid = 1'b0;
        chk("hold_overrun", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("restart_valid",   32'(out_valid), 32'd0);
        chk("restart_busy",    32'(busy), 32'd1);
        chk("restart_overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < WIN; i++) s[i] = 16'h0003;
        feed(s, g);
        check_result("restart", 19'h00018, 16'h0003, 16'h0003);
        release_idle(19'h00018);

        // Reset in mid-window aborts it.
        start_win();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h1000;
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_sum",   32'(out_sum), 32'd0);
        chk("abort_max",   32'(out_max), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        start_win();
        for (int i = 0; i < WIN; i++) s[i] = 16'h0002;
        feed(s, g);
        check_result("post_rst", 19'h00010, 16'h0002, 16'h0002);
        release_idle(19'h00010);

        // start pulsed in ACCUM is ignored.
        start_win();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0010;
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0010;
            tick();
            chk("mid_start_valid", 32'(out_valid), (i == 4) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        check_result("mid_start", 19'h00080, 16'h0010, 16'h0010);
        release_idle(19'h00080);

        // Random windows against the reference.
        start_win();
        for (int w = 0; w < 25; w++) begin
            for (int i = 0; i < WIN; i++) begin
                s[i] = 16'($urandom);
                g[i] = 2'($urandom_range(0, 3));
            end
            model(s, es, ea, em);
            feed(s, g);
            check_result($sformatf("rnd%0d", w), es, ea, em);
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("rnd_stable", 32'(out_sum), 32'(es));
            end
            if ($urandom_range(0, 1) == 1) begin
                out_ready = 1'b1;
                start     = 1'b1;
                tick();
                out_ready = 1'b0;
                start     = 1'b0;
                chk("rnd_b2b_busy", 32'(busy), 32'd1);
            end else begin
                release_idle(es);
                start_win();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
